// File: rtl/led_trail_pkg.sv
// Shared constants and the geometric fade step for the LED trail PWM stage.
package led_trail_pkg;

  localparam int unsigned BRIGHT_W_DEF = 8;
  localparam int unsigned NUM_LEDS_DEF = 6;
  localparam int unsigned BRIGHT_MAX   = (1 << BRIGHT_W_DEF) - 1;

  // Widened to 32 bits so any BRIGHT_W up to 32 can reuse it; never underflows.
  function automatic int unsigned decay_step(input int unsigned bright,
                                             input int unsigned shift);
    int unsigned drop;
    drop = bright >> shift;
    return (drop == 0) ? 0 : bright - drop;
  endfunction

endpackage

// File: rtl/led_trail_pwm_if.sv
// Scanner-to-LED-stage bus: head position in, active-low LED drive and PWM wrap out.
interface led_trail_pwm_if #(
  parameter int NUM_LEDS = 6,
  parameter int POS_W    = 3
);
  logic                pos_valid;
  logic [POS_W-1:0]    pos;
  logic [NUM_LEDS-1:0] led;
  logic                pwm_wrap;

  modport master (output pos_valid, pos, input led, pwm_wrap);
  modport slave  (input pos_valid, pos, output led, pwm_wrap);
endinterface

// File: rtl/led_trail_pwm_channel.sv
// One LED channel: brightness register with head load / geometric decay, PWM compare and
// registered active-low drive. Square-law level when LED_TRAIL_GAMMA_EN is defined.
module led_pwm_channel
  import led_trail_pkg::*;
#(
  parameter int unsigned BRIGHT_W    = BRIGHT_W_DEF,
  parameter int unsigned DECAY_SHIFT = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [BRIGHT_W-1:0] pwm_cnt,
  input  logic                decay_tick,
  input  logic                load_i,
  output logic                led
);

  logic [BRIGHT_W-1:0] bright;
  logic [BRIGHT_W-1:0] level;

  // A head load in the same cycle as a decay tick must leave the channel at full scale.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bright <= '0;
    end else if (load_i) begin
      bright <= '1;
    end else if (decay_tick) begin
      bright <= BRIGHT_W'(decay_step(32'(bright), DECAY_SHIFT));
    end
  end

`ifdef LED_TRAIL_GAMMA_EN
  logic [2*BRIGHT_W-1:0] square;
  assign square = {{BRIGHT_W{1'b0}}, bright} * {{BRIGHT_W{1'b0}}, bright};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      level <= '0;
    end else begin
      level <= square[2*BRIGHT_W-1:BRIGHT_W];
    end
  end
`else
  assign level = bright;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      led <= 1'b1;
    end else begin
      led <= ~(level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_trail_pwm.sv
// LED scanner trail stage: head LED at full brightness, comet-tail fade, per-LED PWM.
// Define LED_TRAIL_GAMMA_EN for a square-law (perceptual) fade with one extra cycle of latency.
module led_trail_pwm
  import led_trail_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = NUM_LEDS_DEF,
  parameter int unsigned POS_W        = 3,
  parameter int unsigned BRIGHT_W     = BRIGHT_W_DEF,
  parameter int unsigned DECAY_SHIFT  = 1,
  parameter int unsigned DECAY_CYCLES = 270000
) (
  input logic             sys_clk,
  input logic             sys_rst,
  led_trail_pwm_if.slave  bus
);

  localparam int unsigned DECAY_W = $clog2(DECAY_CYCLES);

  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [DECAY_W-1:0]  decay_cnt;
  logic                decay_tick;
  logic [NUM_LEDS-1:0] load;
  logic [NUM_LEDS-1:0] led_q;
  logic                pwm_wrap_q;

  assign decay_tick = (decay_cnt == DECAY_W'(DECAY_CYCLES - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      decay_cnt <= '0;
    end else if (decay_tick) begin
      decay_cnt <= '0;
    end else begin
      decay_cnt <= decay_cnt + 1'b1;
    end
  end

  // The wrap pulse is registered so it lines up with pwm_cnt == 0.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pwm_cnt    <= '0;
      pwm_wrap_q <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      pwm_wrap_q <= (pwm_cnt == '1);
    end
  end

  // Out-of-range positions match no channel and are therefore ignored.
  always_comb begin
    load = '0;
    if (bus.pos_valid) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (bus.pos == POS_W'(i)) begin
          load[i] = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .BRIGHT_W    (BRIGHT_W),
      .DECAY_SHIFT (DECAY_SHIFT)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .pwm_cnt    (pwm_cnt),
      .decay_tick (decay_tick),
      .load_i     (load[i]),
      .led        (led_q[i])
    );
  end

  assign bus.led      = led_q;
  assign bus.pwm_wrap = pwm_wrap_q;

endmodule
